// File: rtl/rca_sum_accumulator_pkg.sv
// Shared types and constants for the ripple-carry adder result accumulator.
// Saturating accumulation is selected with the RCA_ACC_SATURATE_EN macro.
package rca_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

  localparam int DEF_IN_W  = 3;
  localparam int DEF_ACC_W = 8;

  // Counter must be able to hold N_SAMPLES itself, not just N_SAMPLES-1.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rca_sum_accumulator_counter.sv
// Sample counter: synchronous clear / increment-enable with a terminal-count
// flag that is high while the count equals N_SAMPLES-1.
module rca_sample_counter #(
  parameter int N_SAMPLES = 4,
  parameter int CNT_W     = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(N_SAMPLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/rca_sum_accumulator.sv
// Accumulates N_SAMPLES adder results {cout,sum} into an ACC_W-bit total.
// Optional macro RCA_ACC_SATURATE_EN clamps the total at all-ones instead of wrapping.
module rca_sum_accumulator
  import rca_acc_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int N_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  sum,
  input  logic             cout,
  output logic [ACC_W-1:0] acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             busy,
  output logic [1:0]       o_state
);

  localparam int CNT_W = cnt_width(N_SAMPLES);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; ready never depends combinationally on valid, and valid/data
  // must be held by the sender until that transfer edge.
  acc_state_e       r_state;
  logic [ACC_W-1:0] r_acc;
  logic             r_overflow;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_xfer;
  logic             w_clr;
  logic             w_tc;
  logic             w_carry;
  logic [ACC_W:0]   w_sample;
  logic [ACC_W:0]   w_sum_ext;
  logic [ACC_W-1:0] w_next_acc;

  assign w_sample  = {{(ACC_W - IN_W){1'b0}}, cout, sum};
  assign w_sum_ext = {1'b0, r_acc} + w_sample;
  assign w_carry   = w_sum_ext[ACC_W];

`ifdef RCA_ACC_SATURATE_EN
  // Once clamped, any further non-zero add carries again and stays clamped.
  assign w_next_acc = w_carry ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
`else
  assign w_next_acc = w_sum_ext[ACC_W-1:0];
`endif

  assign w_xfer = in_valid && r_in_ready;
  assign w_clr  = (r_state == IDLE) && start;

  rca_sample_counter #(
    .N_SAMPLES (N_SAMPLES),
    .CNT_W     (CNT_W)
  ) u_counter (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_clr),
    .i_inc (w_xfer),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_overflow  <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= ACCUM;
            r_acc      <= '0;
            r_overflow <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ACCUM: begin
          if (w_xfer) begin
            r_acc      <= w_next_acc;
            r_overflow <= r_overflow | w_carry;
            if (w_tc) begin
              r_state     <= DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          // acc and overflow stay put through IDLE until the next start.
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign acc       = r_acc;
  assign overflow  = r_overflow;
  assign busy      = r_busy;
  assign o_state   = r_state;

endmodule

// File: tb/tb_rca_sum_accumulator.sv
// Bench for rca_sum_accumulator: default 8-bit instance and a 5-bit instance
// share stimulus; expectations come from plain-arithmetic totals of the run.
module tb_rca_sum_accumulator;
  import rca_acc_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, out_ready, cout;
  logic [2:0] sum;

  logic       in_ready, out_valid, ov8, busy;
  logic [7:0] acc8;
  logic [1:0] state8;
  logic       in_ready5, out_valid5, ov5, busy5;
  logic [4:0] acc5;
  logic [1:0] state5;

  int checks = 0;
  int errors = 0;
  logic [3:0] smp[4];

  always #5 clk = ~clk;

  rca_sum_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .cout(cout), .acc(acc8), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(ov8), .busy(busy), .o_state(state8)
  );

  rca_sum_accumulator #(.IN_W(3), .ACC_W(5), .N_SAMPLES(4)) dut5 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready5),
    .sum(sum), .cout(cout), .acc(acc5), .out_valid(out_valid5), .out_ready(out_ready),
    .overflow(ov5), .busy(busy5), .o_state(state5)
  );

  initial begin
    #400000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // Reference: the accumulator value after adding up 'total' with a W-bit register.
  function automatic int exp_acc(input int total, input int w);
`ifdef RCA_ACC_SATURATE_EN
    return (total > (1 << w) - 1) ? (1 << w) - 1 : total;
`else
    return total % (1 << w);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_state", 32'(state8), 32'(ACCUM));
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_in_ready", 32'(in_ready), 32'd1);
    chk("start_acc8", 32'(acc8), 32'd0);
    chk("start_ov8", 32'(ov8), 32'd0);
    chk("start_acc5", 32'(acc5), 32'd0);
  endtask

  task automatic run_seq(input int gmin, input int gmax, input int hold, input bit poke);
    int total;
    int g;
    logic [7:0] held8;
    total = 0;
    start_run();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      {cout, sum} = smp[i];
      if (poke && i == 2) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b0;
      total += int'(smp[i]);
      chk("acc8_run", 32'(acc8), 32'(exp_acc(total, 8)));
      chk("acc5_run", 32'(acc5), 32'(exp_acc(total, 5)));
      if (i < 3) begin
        chk("out_valid_early", 32'(out_valid), 32'd0);
        chk("in_ready_accum", 32'(in_ready), 32'd1);
        g = $urandom_range(gmax, gmin);
        repeat (g) begin
          {cout, sum} = 4'($urandom_range(0, 15));
          @(negedge clk);
          chk("acc8_gap", 32'(acc8), 32'(exp_acc(total, 8)));
          chk("out_valid_gap", 32'(out_valid), 32'd0);
        end
      end
    end
    chk("done_out_valid", 32'(out_valid), 32'd1);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_ov8", 32'(ov8), 32'(total >= 256));
    chk("done_ov5", 32'(ov5), 32'(total >= 32));
    chk("done_out_valid5", 32'(out_valid5), 32'd1);
    held8 = 8'(exp_acc(total, 8));
    repeat (hold) begin
      if (poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_acc8", 32'(acc8), 32'(held8));
      chk("hold_acc5", 32'(acc5), 32'(exp_acc(total, 5)));
    end
    out_ready = 1'b1;
    if (poke) start = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    chk("ret_state", 32'(state8), 32'(IDLE));
    chk("ret_out_valid", 32'(out_valid), 32'd0);
    chk("ret_busy", 32'(busy), 32'd0);
    chk("ret_in_ready", 32'(in_ready), 32'd0);
    chk("ret_acc8", 32'(acc8), 32'(held8));
    chk("ret_ov5", 32'(ov5), 32'(total >= 32));
    chk("ret_state5", 32'(state5), 32'(IDLE));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cout = 1'b0; sum = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_state", 32'(state8), 32'(IDLE));
    chk("rst_acc8", 32'(acc8), 32'd0);
    chk("rst_ov8", 32'(ov8), 32'd0);

    // Idle: in_valid without start must be ignored.
    in_valid = 1'b1; cout = 1'b1; sum = 3'd7;
    repeat (3) begin
      @(negedge clk);
      chk("idle_acc8", 32'(acc8), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    in_valid = 1'b0;

    // Basic back-to-back run: 0+3+15+5 = 23.
    smp = '{4'd0, 4'd3, 4'd15, 4'd5};
    run_seq(0, 0, 0, 1'b0);
    chk("basic_acc8", 32'(acc8), 32'd23);

    // Input gaps of 2 cycles and 3 cycles of output backpressure.
    run_seq(2, 2, 3, 1'b0);
    chk("gap_acc8", 32'(acc8), 32'd23);

    // Overflow on the 5-bit instance: 60 total.
    smp = '{4'd15, 4'd15, 4'd15, 4'd15};
    run_seq(0, 0, 1, 1'b0);
    chk("ovf_acc5", 32'(acc5), 32'(exp_acc(60, 5)));
    chk("ovf_flag5", 32'(ov5), 32'd1);
    chk("ovf_acc8", 32'(acc8), 32'd60);

    // Reset mid-run discards the partial sum.
    start_run();
    in_valid = 1'b1; {cout, sum} = 4'd3;
    @(negedge clk);
    {cout, sum} = 4'd4;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_acc8", 32'(acc8), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_state", 32'(state8), 32'(IDLE));
    chk("midrst_acc8", 32'(acc8), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    smp = '{4'd1, 4'd2, 4'd3, 4'd4};
    run_seq(0, 1, 0, 1'b0);
    chk("fresh_acc8", 32'(acc8), 32'd10);

    // start pulses during ACCUM, DONE and alongside out_ready are ignored.
    smp = '{4'd0, 4'd3, 4'd15, 4'd5};
    run_seq(0, 1, 2, 1'b1);
    chk("ignored_start_acc8", 32'(acc8), 32'd23);
    @(negedge clk);
    chk("ignored_start_idle", 32'(state8), 32'(IDLE));

    // Randomized runs against the arithmetic model.
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 4; k++) smp[k] = 4'($urandom_range(0, 15));
      run_seq(0, 2, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rca_sum_accumulator.md
Name: rca_sum_accumulator

Overview:
- Downstream consumer of the 3-bit ripple-carry adder stage; takes its sum/cout result as one (IN_W+1)-bit value.
- Accumulates a fixed number of adder results (N_SAMPLES) into a wider register under a valid/ready handshake.
- Presents the final total with an output valid/ready handshake and a sticky overflow flag.
- Lab datapath element that turns the combinational adder into a multi-cycle summing unit.

Parameters:
- IN_W, 3, width of adder sum input; adder result value is {cout, sum}, IN_W+1 bits, zero-extended.
- ACC_W, 8, accumulator width; must be >= IN_W+1.
- N_SAMPLES, 4, number of accepted samples per accumulation run; must be >= 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a run; honoured only in IDLE.
- in_valid  input  1  upstream adder result is valid.
- in_ready  output  1  block can accept a sample.
- sum  input  IN_W  adder sum bits.
- cout  input  1  adder carry-out.
- acc  output  ACC_W  running/final accumulated value.
- out_valid  output  1  final result available.
- out_ready  input  1  downstream accepts result.
- overflow  output  1  sticky; set if any add carried out of ACC_W in this run.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, acc=0, count=0, overflow=0, in_ready=0, out_valid=0, busy=0. Reset in any state, including mid-run, aborts the run; partial sums are discarded.
- FSM states IDLE, ACCUM, DONE; outputs are Moore, derived from registered state.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - On start: acc<=0, overflow<=0, count<=0, go to ACCUM.
- ACCUM:
  - in_ready=1.
  - A transfer occurs when in_valid && in_ready. On transfer: acc<=acc+{cout,sum}, the sum taken modulo 2^ACC_W; overflow<=overflow | carry-out of bit ACC_W-1; count<=count+1.
  - On the transfer where count==N_SAMPLES-1, go to DONE.
  - start is ignored.
- DONE:
  - out_valid=1, in_ready=0; acc and overflow are held stable.
  - On out_ready: go to IDLE. acc and overflow keep their values until the next start.
  - start in the same cycle as out_ready is ignored; a new run needs start in IDLE.
- Latency: out_valid asserts one cycle after the final accepted sample. Minimum run is N_SAMPLES+2 cycles from start to return to IDLE.
- Throughput: one sample per cycle while in ACCUM with in_valid held high.
- count width is clog2(N_SAMPLES+1). N_SAMPLES=1 goes to DONE on the first transfer.
- acc is visible (running value) during ACCUM; it is meaningful to downstream only while out_valid=1.

Optional Feature:
- Macro RCA_ACC_SATURATE_EN.
- Defined: an add that would exceed 2^ACC_W-1 clamps acc to all-ones. overflow is still set, and later adds remain clamped.
- Undefined: wrap-around modulo 2^ACC_W, as described in Behaviour.

Decomposition:
- Package rca_acc_pkg holds:
  - state enum acc_state_e {IDLE, ACCUM, DONE};
  - default width constants (IN_W, ACC_W);
  - a function computing the counter width.
- One sub-module, rca_sample_counter: clear / increment-enable counter with terminal-count output at N_SAMPLES-1. The FSM and the adder/saturation datapath stay in the top module.

Test Plan:
- Reset and idle: rst for 2 cycles, then in_valid=1 with no start -> acc=0, in_ready=0, out_valid=0, busy=0 throughout.
- Basic run (defaults): start, then samples {cout,sum} = 0, 3, 15 (cout=1, sum=7), 5, back to back -> out_valid exactly one cycle after the 4th transfer, acc=23, overflow=0. With out_ready=1 -> IDLE on the next edge.
- Gaps and backpressure:
  - Input side: in_valid low for 2 cycles between samples -> those cycles do not change acc or count.
  - Output side: out_ready held low 3 cycles in DONE -> acc=23 and out_valid=1 held stable.
- Overflow, ACC_W=5: four samples of 15 -> acc=28, overflow=1 with the macro undefined; acc=31, overflow=1 with RCA_ACC_SATURATE_EN defined.
- Reset mid-run: start, accept 2 samples (3, 4), assert rst -> next cycle state=IDLE, acc=0, in_ready=0. A new start then gives a fresh run that does not include the old partial sum.
- Ignored start: pulse start during ACCUM and during DONE -> no restart; count and acc are unaffected; result equals the clean-run value.
